comparator_pipe: RTL
====================

COMPARATOR_PIPE -- requirements
Module: comparator_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits (multiple of 8, range 8..256).
REQ-002 SHALL have parameter CNT_W, default 16, match counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state rising-edge triggered.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operand set this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  operand A.
REQ-008 SHALL have port in_b  input  WIDTH  operand B.
REQ-009 SHALL have port in_mask  input  WIDTH  compare-enable per bit (1 = compared).
REQ-010 SHALL have port in_mode  input  2  00 EQ, 01 NE, 10 LT (A<B), 11 GE (A>=B), unsigned.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_match  output  1  result per captured mode.
REQ-014 SHALL have port out_eq  output  1  masked A equals masked B.
REQ-015 SHALL have port out_lt  output  1  masked A less than masked B, unsigned.
REQ-016 SHALL have port cnt_clr  input  1  synchronous match-counter clear.
REQ-017 SHALL have port match_cnt  output  CNT_W  count of accepted results with out_match=1.

Function
REQ-018 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 Masking: SHALL compare (in_a & in_mask) against (in_b & in_mask); in_mask=0 yields out_eq=1, out_lt=0.
REQ-020 Stage 1 SHALL register, per 8-bit chunk, chunk-equal and chunk-less-than flags plus captured mode.
REQ-021 Stage 2 SHALL reduce chunk flags: eq = AND of all chunk-equal; lt = most-significant unequal chunk's lt flag.
REQ-022 out_match SHALL be eq (EQ), !eq (NE), lt (LT), !lt (GE) using mode captured with that operand set.
REQ-023 Latency SHALL be exactly 2 cycles from input transfer to out_valid when unstalled.
REQ-024 Pipeline SHALL advance iff !(out_valid && !out_ready); in_ready SHALL equal this advance term (combinational from out_ready).
REQ-025 Throughput SHALL be one transfer per cycle with out_ready held 1.
REQ-026 While stalled, out_valid, out_match, out_eq, out_lt SHALL hold stable; no operand set lost or duplicated.
REQ-027 Bubbles (stage valid 0) SHALL propagate; out_valid=0 when stage 2 empty; out_match/out_eq/out_lt don't-care then.
REQ-028 match_cnt SHALL increment by 1 on each output transfer with out_match=1.
REQ-029 match_cnt SHALL saturate at 2^CNT_W-1, no wrap.
REQ-030 cnt_clr SHALL set match_cnt to 0 next cycle, taking priority over a same-cycle increment.
REQ-031 in_mode, in_mask changes SHALL affect only operand sets transferred after the change.

Reset
REQ-032 On rst_n=0, stage valids, out_valid, out_match, out_eq, out_lt, match_cnt SHALL go 0 immediately, independent of clk.
REQ-033 During reset in_ready SHALL read 1; no transfer counted until first clk edge after rst_n deasserts.
REQ-034 Reset mid-stream SHALL discard all in-flight operand sets without counting them.

Verification
REQ-035 WIDTH=64, mode EQ, A=B=0xDEADBEEF_01234567, mask all ones, out_ready=1 -> out_valid at cycle+2, out_match=1, out_eq=1, match_cnt=1.
REQ-036 Mode LT, A=0x00FF..., B=0x0100..., mask all ones -> out_lt=1, out_match=1; same with mode GE -> out_match=0, count unchanged.
REQ-037 A=0x...FF, B=0x...00, mask=0x...00 (low byte masked off), mode EQ -> out_eq=1; mask all zero, mode LT -> out_lt=0.
REQ-038 Back-to-back 8 EQ hits, out_ready low for 3 cycles mid-stream -> outputs hold while stalled, in_ready=0 while stalled, all 8 delivered in order, match_cnt=8.
REQ-039 CNT_W=3, 9 matching transfers -> match_cnt stays 7; cnt_clr asserted with concurrent match -> match_cnt=0.
REQ-040 rst_n pulsed low between clocks with 2 operands in flight -> out_valid=0 and match_cnt=0 immediately; next transfer appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/comparator_pipe.sv
// -----------------------------------------------------------------------------
// comparator_pipe
//   Two-stage masked unsigned comparator with valid/ready handshake and a
//   saturating counter of delivered matches.
//
//   Stage 1 registers per-byte equal / less-than flags of the masked operands
//   together with the compare mode. Stage 2 reduces the byte flags to a full
//   width eq / lt result and evaluates the mode to produce out_match.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented
//   in_ready   pipeline can accept an operand set this cycle
//   in_a/in_b  operands (WIDTH bits, unsigned)
//   in_mask    per-bit compare enable (1 = bit takes part)
//   in_mode    00 EQ, 01 NE, 10 LT (A<B), 11 GE (A>=B)
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_match  result of the mode captured with the operand set
//   out_eq     masked A == masked B
//   out_lt     masked A <  masked B
//   cnt_clr    synchronous clear of match_cnt (wins over increment)
//   match_cnt  saturating count of delivered results with out_match = 1
// -----------------------------------------------------------------------------
module comparator_pipe #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_match,
  output logic             out_eq,
  output logic             out_lt,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int NCH = WIDTH / 8;

  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_NE = 2'b01;
  localparam logic [1:0] MODE_LT = 2'b10;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic mode_match(input logic [1:0] mode, input logic eq, input logic lt);
    case (mode)
      MODE_EQ: return eq;
      MODE_NE: return !eq;
      MODE_LT: return lt;
      default: return !lt;
    endcase
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [NCH-1:0]   w_ceq;
  logic [NCH-1:0]   w_clt;
  logic             w_eq;
  logic             w_lt;

  logic             r_vld_p1;
  logic [NCH-1:0]   r_ceq_p1;
  logic [NCH-1:0]   r_clt_p1;
  logic [1:0]       r_mode_p1;

  logic             r_vld_p2;
  logic             r_match_p2;
  logic             r_eq_p2;
  logic             r_lt_p2;
  logic [CNT_W-1:0] r_cnt;

  // The whole pipeline moves together; it only freezes while a result sits
  // at the output unaccepted, so in_ready follows out_ready combinationally.
  assign w_adv    = !(r_vld_p2 && !out_ready);
  assign in_ready = w_adv;

  assign w_ma = in_a & in_mask;
  assign w_mb = in_b & in_mask;

  // ---- stage 0 -> 1 : per-byte flags of the masked operands ----
  always_comb begin
    w_ceq = '0;
    w_clt = '0;
    for (int c = 0; c < NCH; c++) begin
      w_ceq[c] = (w_ma[c*8 +: 8] == w_mb[c*8 +: 8]);
      w_clt[c] = (w_ma[c*8 +: 8] <  w_mb[c*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_ceq_p1  <= w_ceq;
      r_clt_p1  <= w_clt;
      r_mode_p1 <= in_mode;
    end
  end

  // ---- stage 1 -> 2 : reduce byte flags, evaluate mode ----
  // Ascending scan: the highest unequal byte is the last to write w_lt and
  // therefore decides the ordering.
  always_comb begin
    w_eq = 1'b1;
    w_lt = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      w_eq = w_eq & r_ceq_p1[c];
      if (!r_ceq_p1[c]) w_lt = r_clt_p1[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_match_p2 <= 1'b0;
      r_eq_p2    <= 1'b0;
      r_lt_p2    <= 1'b0;
    end else if (w_adv) begin
      r_vld_p2   <= r_vld_p1;
      r_match_p2 <= mode_match(r_mode_p1, w_eq, w_lt);
      r_eq_p2    <= w_eq;
      r_lt_p2    <= w_lt;
    end
  end

  // ---- output : match counter on delivered results ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (r_vld_p2 && out_ready && r_match_p2) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign out_valid = r_vld_p2;
  assign out_match = r_match_p2;
  assign out_eq    = r_eq_p2;
  assign out_lt    = r_lt_p2;
  assign match_cnt = r_cnt;

endmodule
